// File: rtl/pwm_pkg.sv
// Shared types for the PWM fade controller: duty code width, duty type and FSM states.
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    // Clock cycles per 1-LSB duty step.
    function automatic int step_count(input int clk_hz, input int step_us);
        return (clk_hz / 1000000) * step_us;
    endfunction

endpackage

// File: rtl/pwm_step_tick.sv
// Ramp prescaler: counts enabled, non-held cycles and pulses tick on the terminal count.
module pwm_step_tick #(
    parameter int STEP_COUNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = $clog2(STEP_COUNT + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STEP_COUNT - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && !hold && (count == TERMINAL);

    // Hold freezes the count so stepping resumes exactly where it stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !hold) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade controller: jumps or ramps the PWM duty code toward a requested target.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int C_CLK_FREQ_HZ = 100000000,
    parameter int C_STEP_US     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              target_immediate,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic              hold,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_cycle_valid,
    output logic              ramp_active,
    output logic              ramp_done
);

    localparam int STEP_COUNT = step_count(C_CLK_FREQ_HZ, C_STEP_US);

    generate
        if (STEP_COUNT < 1) begin : g_bad_step
            $error("pwm_fade_ctrl: STEP_COUNT must be at least 1");
        end
    endgenerate

    state_t state;
    duty_t  target_q;
    duty_t  step_val;
    logic   dir_up;
    logic   accept;
    logic   tick;

    // Handshake: a request transfers on the rising edge where target_valid && target_ready.
    assign accept   = target_valid && target_ready && (state == ST_IDLE);
    assign step_val = dir_up ? duty_cycle + 1'b1 : duty_cycle - 1'b1;

    // Prescaler sits at zero throughout IDLE, so every ramp starts from a clean count.
    pwm_step_tick #(
        .STEP_COUNT(STEP_COUNT)
    ) u_step_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable (state == ST_RAMP),
        .hold   (hold),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            duty_cycle       <= '0;
            duty_cycle_valid <= 1'b0;
            ramp_done        <= 1'b0;
            ramp_active      <= 1'b0;
            target_ready     <= 1'b0;
            target_q         <= '0;
            dir_up           <= 1'b0;
        end else begin
            duty_cycle_valid <= 1'b0;
            ramp_done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target_ready <= 1'b0;
                        if (target_immediate) begin
                            duty_cycle       <= target_duty;
                            duty_cycle_valid <= 1'b1;
                            ramp_done        <= 1'b1;
                        end else if (target_duty == duty_cycle) begin
                            ramp_done <= 1'b1;
                        end else begin
                            target_q    <= target_duty;
                            dir_up      <= (target_duty > duty_cycle);
                            state       <= ST_RAMP;
                            ramp_active <= 1'b1;
                        end
                    end else begin
                        target_ready <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    target_ready <= 1'b0;
                    if (tick) begin
                        duty_cycle       <= step_val;
                        duty_cycle_valid <= 1'b1;
                        if (step_val == target_q) begin
                            ramp_done   <= 1'b1;
                            state       <= ST_IDLE;
                            ramp_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ramp_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
